// File: rtl/key_debouncer.sv
// Debounces raw keys/switches; emits clean levels, press pulses and auto-repeat pulses.
// Latency: 2 sync + DEBOUNCE_CYCLES edges to KEYClean/KEYPress; no backpressure, pulses are never held off.
module key_debouncer #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         REPEAT_DELAY    = 25000000,
  parameter int         REPEAT_RATE     = 5000000,
  parameter logic [3:0] REPEAT_MASK     = 4'b1000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] KEY,
  input  logic       SW,
  input  logic       SW2,
  output logic [3:0] KEYClean,
  output logic [3:0] KEYPress,
  output logic [3:0] KEYHeld,
  output logic       SWClean,
  output logic       SW2Clean
);

  localparam int DBW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RPMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW   = $clog2(RPMAX);
  localparam logic [DBW-1:0] DB_TERM    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPW-1:0] DELAY_TERM = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RATE_TERM  = RPW'(REPEAT_RATE - 1);
  // Keys idle high (active-low), switches idle low.
  localparam logic [5:0] IN_INIT = 6'b001111;

  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} kstate_t;

  logic [5:0] raw, sync1, sync2, stable;
  logic [3:0] key_stable_nxt;

  assign raw = {SW2, SW, KEY};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= IN_INIT;
      sync2 <= IN_INIT;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_db
    logic [DBW-1:0] cnt, cnt_nxt;
    logic           st, st_nxt;

    always_comb begin
      st_nxt  = st;
      cnt_nxt = '0;
      if (sync2[i] != st) begin
        if (cnt == DB_TERM) st_nxt = sync2[i];
        else                cnt_nxt = cnt + 1'b1;
      end
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        st  <= IN_INIT[i];
        cnt <= '0;
      end else begin
        st  <= st_nxt;
        cnt <= cnt_nxt;
      end
    end

    assign stable[i] = st;
    if (i < 4) begin : g_key_nxt
      assign key_stable_nxt[i] = st_nxt;
    end
  end

  // The FSM looks at the next stable value so press pulses and release
  // transitions land on the same edge as the KEYClean change.
  for (genvar k = 0; k < 4; k++) begin : g_key
    kstate_t        state, state_nxt;
    logic [RPW-1:0] rcnt, rcnt_nxt;
    logic           press, press_nxt;

    always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      press_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (stable[k] && !key_stable_nxt[k]) begin
            press_nxt = 1'b1;
            rcnt_nxt  = '0;
            state_nxt = PRESSED;
          end
        end
        PRESSED: begin
          if (key_stable_nxt[k]) begin
            rcnt_nxt  = '0;
            state_nxt = IDLE;
          end else if (REPEAT_MASK[k]) begin
            if (rcnt == DELAY_TERM) begin
              press_nxt = 1'b1;
              rcnt_nxt  = '0;
              state_nxt = REPEAT;
            end else begin
              rcnt_nxt = rcnt + 1'b1;
            end
          end else begin
            rcnt_nxt = '0;
          end
        end
        REPEAT: begin
          if (key_stable_nxt[k]) begin
            rcnt_nxt  = '0;
            state_nxt = IDLE;
          end else if (rcnt == RATE_TERM) begin
            press_nxt = 1'b1;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
        default: begin
          rcnt_nxt  = '0;
          state_nxt = IDLE;
        end
      endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        state <= IDLE;
        rcnt  <= '0;
        press <= 1'b0;
      end else begin
        state <= state_nxt;
        rcnt  <= rcnt_nxt;
        press <= press_nxt;
      end
    end

    assign KEYPress[k] = press;
    assign KEYHeld[k]  = (state == REPEAT);
  end

  assign KEYClean = stable[3:0];
  assign SWClean  = stable[4];
  assign SW2Clean = stable[5];

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with small sim parameters (4/10/3, repeat on KEY3).
module tb_key_debouncer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] KEY;
  logic       SW, SW2;
  logic [3:0] KEYClean, KEYPress, KEYHeld;
  logic       SWClean, SW2Clean;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] press_log [64];
  logic [3:0] clean_log [64];
  logic [3:0] held_log  [64];
  logic       swc_log   [64];
  logic       sw2c_log  [64];

  key_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3),
    .REPEAT_MASK    (4'b1000)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .KEY     (KEY),
    .SW      (SW),
    .SW2     (SW2),
    .KEYClean(KEYClean),
    .KEYPress(KEYPress),
    .KEYHeld (KEYHeld),
    .SWClean (SWClean),
    .SW2Clean(SW2Clean)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_logs();
    for (int e = 0; e < 64; e++) begin
      press_log[e] = 4'h0;
      clean_log[e] = 4'hF;
      held_log[e]  = 4'h0;
      swc_log[e]   = 1'b0;
      sw2c_log[e]  = 1'b0;
    end
  endtask

  // Log outputs 1 time unit after edge e.
  task automatic tick(input int e);
    @(posedge Clk);
    #1;
    press_log[e] = KEYPress;
    clean_log[e] = KEYClean;
    held_log[e]  = KEYHeld;
    swc_log[e]   = SWClean;
    sw2c_log[e]  = SW2Clean;
  endtask

  task automatic run(input int n);
    clear_logs();
    for (int e = 1; e <= n; e++) tick(e);
  endtask

  function automatic logic [63:0] pmask(input int b);
    logic [63:0] m;
    m = '0;
    for (int e = 1; e < 64; e++) m[e] = press_log[e][b];
    return m;
  endfunction

  function automatic logic [63:0] hmask(input int b);
    logic [63:0] m;
    m = '0;
    for (int e = 1; e < 64; e++) m[e] = held_log[e][b];
    return m;
  endfunction

  function automatic logic [63:0] bit_at(input int e);
    return 64'd1 << e;
  endfunction

  initial begin
    logic [63:0] m;
    logic        acc;

    Reset = 1'b1;
    KEY   = 4'hF;
    SW    = 1'b0;
    SW2   = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_clean", KEYClean, 4'hF);
    chk("rst_press", KEYPress, 4'h0);
    chk("rst_held",  KEYHeld,  4'h0);
    chk("rst_sw",    SWClean,  1'b0);
    chk("rst_sw2",   SW2Clean, 1'b0);
    Reset = 1'b0;
    run(8);
    chk("idle_clean", clean_log[8], 4'hF);
    chk("idle_nopress", pmask(0) | pmask(1) | pmask(2) | pmask(3), 64'd0);

    // Clean press of KEY1 held for 20 cycles
    KEY = 4'b1101;
    run(20);
    chk("k1_clean_e5", clean_log[5][1], 1'b1);
    chk("k1_clean_e6", clean_log[6][1], 1'b0);
    chk("k1_press",    pmask(1), bit_at(6));
    chk("k1_held",     hmask(1), 64'd0);
    KEY = 4'hF;
    run(12);
    chk("k1_release_nopulse", pmask(1), 64'd0);
    chk("k1_release_clean",   clean_log[12], 4'hF);

    // KEY0 bounce: 0,0,1,1,0,0,1,1 then steady 0 from edge 9
    clear_logs();
    for (int e = 1; e <= 24; e++) begin
      KEY[0] = (e <= 2) ? 1'b0 : (e <= 4) ? 1'b1 : (e <= 6) ? 1'b0 : (e <= 8) ? 1'b1 : 1'b0;
      tick(e);
    end
    acc = 1'b1;
    for (int e = 1; e <= 13; e++) acc = acc & clean_log[e][0];
    chk("k0_bounce_quiet", acc, 1'b1);
    chk("k0_clean_e14",    clean_log[14][0], 1'b0);
    chk("k0_press",        pmask(0), bit_at(14));
    KEY = 4'hF;
    run(12);

    // KEY3 held for 30 cycles: press, delay, repeats until release is debounced at edge 36
    clear_logs();
    for (int e = 1; e <= 45; e++) begin
      KEY[3] = (e <= 30) ? 1'b0 : 1'b1;
      tick(e);
    end
    m = bit_at(6) | bit_at(16) | bit_at(19) | bit_at(22) | bit_at(25) | bit_at(28) | bit_at(31) | bit_at(34);
    chk("k3_pulses",    pmask(3), m);
    chk("k3_held",      hmask(3), ((64'd1 << 36) - 64'd1) & ~((64'd1 << 16) - 64'd1));
    chk("k3_clean_e35", clean_log[35][3], 1'b0);
    chk("k3_clean_e36", clean_log[36][3], 1'b1);
    KEY = 4'hF;
    run(12);

    // KEY1 and KEY2 together
    KEY = 4'b1001;
    run(12);
    chk("k12_press_e5", press_log[5], 4'b0000);
    chk("k12_press_e6", press_log[6], 4'b0110);
    chk("k12_press_e7", press_log[7], 4'b0000);
    KEY = 4'hF;
    run(12);
    chk("k12_release", pmask(1) | pmask(2), 64'd0);

    // SW glitch of 3 cycles is rejected, then a held level is accepted
    clear_logs();
    for (int e = 1; e <= 12; e++) begin
      SW = (e <= 3);
      tick(e);
    end
    acc = 1'b0;
    for (int e = 1; e <= 12; e++) acc = acc | swc_log[e];
    chk("sw_glitch", acc, 1'b0);
    SW  = 1'b1;
    SW2 = 1'b1;
    run(10);
    chk("sw_e5",  swc_log[5], 1'b0);
    chk("sw_e6",  swc_log[6], 1'b1);
    chk("sw2_e5", sw2c_log[5], 1'b0);
    chk("sw2_e6", sw2c_log[6], 1'b1);
    chk("sw_nopress", pmask(0) | pmask(1) | pmask(2) | pmask(3), 64'd0);
    SW  = 1'b0;
    SW2 = 1'b0;
    run(10);
    chk("sw_low_e6", swc_log[6], 1'b0);

    // Reset while KEY3 is repeating and still held
    KEY = 4'b0111;
    run(19);
    chk("rpt_pre_press", press_log[19][3], 1'b1);
    chk("rpt_pre_held",  held_log[19][3],  1'b1);
    Reset = 1'b1;
    #1;
    chk("rpt_rst_clean", KEYClean, 4'hF);
    chk("rpt_rst_press", KEYPress, 4'h0);
    chk("rpt_rst_held",  KEYHeld,  4'h0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    run(26);
    chk("rpt_after_rst", pmask(3), bit_at(6) | bit_at(16) | bit_at(19) | bit_at(22) | bit_at(25));
    chk("rpt_after_held", held_log[15][3], 1'b0);
    KEY = 4'hF;
    run(12);
    chk("final_clean", clean_log[12], 4'hF);
    chk("final_held",  held_log[12],  4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
